// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, one-entry fetch/decode holding register and BOOT/RUN/STOP control.
// Optional build macro IFETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky fault instead of being truncated.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  input  logic        fd_ready,
  output logic        fd_valid,
  output logic [63:0] fd_pc,
  output logic [31:0] fd_instr,
  output logic [31:0] fetch_count,
  output logic        fault
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]  state_r, state_nxt_s;
  logic [63:0] pc_r, pc_nxt_s;
  logic        fd_valid_r, fd_valid_nxt_s;
  logic [63:0] fd_pc_r, fd_pc_nxt_s;
  logic [31:0] fd_instr_r, fd_instr_nxt_s;
  logic [31:0] fetch_count_r, fetch_count_nxt_s;
  logic        handshake_s;
  logic        misalign_s;
  logic        fault_s;
  logic [63:0] redirect_tgt_s;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_r;

  assign misalign_s     = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt_s = redirect_pc;
  assign fault_s        = fault_r;

  // Sticky fault: set by the first misaligned redirect, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_r <= 1'b0;
    end else if (misalign_s && !fault_r) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end
`else
  logic lint_unused_s;

  // Low address bits are dropped so the PC stays word aligned.
  assign misalign_s     = 1'b0;
  assign redirect_tgt_s = {redirect_pc[63:2], 2'b00};
  assign fault_s        = 1'b0;
  assign lint_unused_s  = ^redirect_pc[1:0];
`endif

  assign handshake_s = fd_valid_r && fd_ready;

  // Next-state logic: a redirect overrides fetch and stall in every state.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    fd_valid_nxt_s = fd_valid_r;
    fd_pc_nxt_s    = fd_pc_r;
    fd_instr_nxt_s = fd_instr_r;
    if (redirect_valid && !fault_s) begin
      fd_valid_nxt_s = 1'b0;
      if (misalign_s) begin
        state_nxt_s = S_STOP;
        pc_nxt_s    = pc_r;
      end else begin
        pc_nxt_s = redirect_tgt_s;
        if (halt && (state_r != S_BOOT)) begin
          state_nxt_s = S_STOP;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
    end else begin
      case (state_r)
        S_BOOT: begin
          state_nxt_s    = S_RUN;
          fd_valid_nxt_s = 1'b0;
        end
        S_RUN: begin
          if (halt) begin
            state_nxt_s = S_STOP;
            if (handshake_s) begin
              fd_valid_nxt_s = 1'b0;
            end else begin
              fd_valid_nxt_s = fd_valid_r;
            end
          end else if (!fd_valid_r || fd_ready) begin
            fd_pc_nxt_s    = pc_r;
            fd_instr_nxt_s = Instruction;
            fd_valid_nxt_s = 1'b1;
            pc_nxt_s       = pc_r + 64'd4;
          end else begin
            fd_valid_nxt_s = fd_valid_r;
          end
        end
        S_STOP: begin
          if (halt || fault_s) begin
            state_nxt_s = S_STOP;
          end else begin
            state_nxt_s = S_RUN;
          end
          if (handshake_s) begin
            fd_valid_nxt_s = 1'b0;
          end else begin
            fd_valid_nxt_s = fd_valid_r;
          end
        end
        default: begin
          state_nxt_s    = S_BOOT;
          fd_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Saturating count of instructions accepted by decode.
  always_comb begin
    if (handshake_s && (fetch_count_r != 32'hFFFF_FFFF)) begin
      fetch_count_nxt_s = fetch_count_r + 32'd1;
    end else begin
      fetch_count_nxt_s = fetch_count_r;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_BOOT;
      pc_r          <= RESET_PC;
      fd_valid_r    <= 1'b0;
      fd_pc_r       <= 64'h0;
      fd_instr_r    <= 32'h0;
      fetch_count_r <= 32'h0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      fd_valid_r    <= fd_valid_nxt_s;
      fd_pc_r       <= fd_pc_nxt_s;
      fd_instr_r    <= fd_instr_nxt_s;
      fetch_count_r <= fetch_count_nxt_s;
    end
  end

  assign Inst_Address = pc_r;
  assign fd_valid     = fd_valid_r;
  assign fd_pc        = fd_pc_r;
  assign fd_instr     = fd_instr_r;
  assign fetch_count  = fetch_count_r;
  assign fault        = fault_s;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        fd_ready;
  logic        fd_valid;
  logic [63:0] fd_pc;
  logic [31:0] fd_instr;
  logic [31:0] fetch_count;
  logic        fault;

  logic        rst2;
  logic [63:0] addr2;
  logic [31:0] instr2;
  logic        fd_valid2;
  logic [63:0] fd_pc2;
  logic [31:0] fd_instr2;
  logic [31:0] count2;
  logic        fault2;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [63:0] m_pc;
  logic        m_boot;
  logic        m_stopped;
  logic        m_fault;
  logic        m_valid;
  logic [63:0] m_fd_pc;
  logic [31:0] m_fd_instr;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0030_0293;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  assign Instruction = mem_word(Inst_Address);
  assign instr2      = mem_word(addr2);

  ifetch_unit u_dut (
    .clk(clk), .reset(reset), .Inst_Address(Inst_Address), .Instruction(Instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .fd_ready(fd_ready), .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_instr(fd_instr),
    .fetch_count(fetch_count), .fault(fault)
  );

  ifetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(rst2), .Inst_Address(addr2), .Instruction(instr2),
    .redirect_valid(1'b0), .redirect_pc(64'h0), .halt(1'b0),
    .fd_ready(1'b1), .fd_valid(fd_valid2), .fd_pc(fd_pc2), .fd_instr(fd_instr2),
    .fetch_count(count2), .fault(fault2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_boot = 1'b1; m_stopped = 1'b0; m_fault = 1'b0;
    m_valid = 1'b0; m_fd_pc = 64'h0; m_fd_instr = 32'h0; m_count = 32'h0;
  endtask

  // One clock of the fetch stage expressed as rules on the visible state.
  task automatic model_update();
    logic take;
    logic bad;
    take = m_valid && fd_ready;
`ifdef IFETCH_ALIGN_CHECK_EN
    bad = (redirect_pc % 64'd4) != 64'd0;
`else
    bad = 1'b0;
`endif
    if (take && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    if (redirect_valid && !m_fault) begin
      m_valid = 1'b0;
      if (bad) m_fault = 1'b1;
      else m_pc = redirect_pc - (redirect_pc % 64'd4);
      m_stopped = m_boot ? 1'b0 : halt;
    end else if (!m_boot) begin
      if (!m_stopped && !halt && !m_fault && (!m_valid || fd_ready)) begin
        m_fd_pc    = m_pc;
        m_fd_instr = mem_word(m_pc);
        m_valid    = 1'b1;
        m_pc       = m_pc + 64'd4;
      end else if (take) begin
        m_valid = 1'b0;
      end
      m_stopped = halt;
    end
    m_boot = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".fd_valid"}, {63'h0, fd_valid}, {63'h0, m_valid});
    chk({tag, ".addr"}, Inst_Address, m_pc);
    chk({tag, ".count"}, {32'h0, fetch_count}, {32'h0, m_count});
    chk({tag, ".fault"}, {63'h0, fault}, {63'h0, m_fault});
    if (m_valid) begin
      chk({tag, ".fd_pc"}, fd_pc, m_fd_pc);
      chk({tag, ".fd_instr"}, {32'h0, fd_instr}, {32'h0, m_fd_instr});
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [63:0] rp, input logic hl);
    @(negedge clk);
    fd_ready = rdy; redirect_valid = rv; redirect_pc = rp; halt = hl;
    model_update();
    @(posedge clk);
    #1;
    compare_all("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst.fd_valid", {63'h0, fd_valid}, 64'h0);
    chk("rst.fd_pc", fd_pc, 64'h0);
    chk("rst.fd_instr", {32'h0, fd_instr}, 64'h0);
    chk("rst.count", {32'h0, fetch_count}, 64'h0);
    chk("rst.addr", Inst_Address, 64'h0);
    chk("rst.fault", {63'h0, fault}, 64'h0);
    @(posedge clk);
    #3 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; rst2 = 1'b0;
    fd_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; halt = 1'b0;
    model_reset();
    do_reset();

    // boot bubble then first fetch
    step(1'b1, 1'b0, 64'h0, 1'b0);
    chk("boot.bubble", {63'h0, fd_valid}, 64'h0);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    chk("first.fd_pc", fd_pc, 64'h0);
    chk("first.instr", {32'h0, fd_instr}, 64'h0030_0293);
    chk("first.addr", Inst_Address, 64'h4);

    // three stall cycles, then resume
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
    chk("stall.fd_pc", fd_pc, 64'h0);
    chk("stall.addr", Inst_Address, 64'h4);
    chk("stall.count", {32'h0, fetch_count}, 64'h0);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    chk("resume.fd_pc", fd_pc, 64'h4);

    // redirect while stalled drops the held instruction
    step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b1, 64'h8, 1'b0);
    chk("redir.bubble", {63'h0, fd_valid}, 64'h0);
    chk("redir.count", {32'h0, fetch_count}, 64'h1);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    chk("redir.fd_pc", fd_pc, 64'h8);
    chk("redir.valid", {63'h0, fd_valid}, 64'h1);

    // redirect with halt: pc moves, fetch stops until halt drops
    step(1'b1, 1'b1, 64'h100, 1'b1);
    chk("rh.addr", Inst_Address, 64'h100);
    step(1'b1, 1'b0, 64'h0, 1'b1);
    chk("rh.stop", {63'h0, fd_valid}, 64'h0);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    chk("rh.fd_pc", fd_pc, 64'h100);

    // misaligned redirect
    step(1'b1, 1'b1, 64'h6, 1'b0);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis.fault", {63'h0, fault}, 64'h1);
    chk("mis.addr", Inst_Address, 64'h104);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    chk("mis.nofetch", {63'h0, fd_valid}, 64'h0);
`else
    chk("mis.addr", Inst_Address, 64'h4);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    chk("mis.fd_pc", fd_pc, 64'h4);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [63:0] rp;
      rp = {$urandom, $urandom};
`ifdef IFETCH_ALIGN_CHECK_EN
      rp[1:0] = 2'b00;
`endif
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, rp, $urandom_range(0, 19) < 3);
    end

    // reset during a stall with five instructions counted
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 64'h0, 1'b0);
    chk("pre.count", {32'h0, fetch_count}, 64'h5);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 64'h0, 1'b0);
    chk("post.bubble", {63'h0, fd_valid}, 64'h0);
    chk("post.addr", Inst_Address, 64'h0);

    // pc wrap from the top of the address space
    @(negedge clk);
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("wrap.bubble", {63'h0, fd_valid2}, 64'h0);
    @(posedge clk); #1;
    chk("wrap.fd_pc1", fd_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap.fd_pc2", fd_pc2, 64'h0);
    chk("wrap.addr", addr2, 64'h4);
    chk("wrap.count", {32'h0, count2}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
